// File: rtl/serial_bus_arbiter.sv
// Two-master serial bus arbiter with split-slave parking/resume and grant timeout.
// Optional ARB_ROUND_ROBIN_EN: alternate on simultaneous requests (else m1 fixed priority).
module serial_bus_arbiter #(
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic m1_split,
  output logic m2_split,
  input  logic tx_done,
  input  logic s3_split,
  output logic s3_split_grant,
  output logic msel,
  output logic bus_busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;       // 0 = m1, 1 = m2
  logic       resumed, resumed_nxt;   // current grant is a split resume
  logic       park_vld, park_vld_nxt;
  logic       park_own, park_own_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       m1_split_nxt, m2_split_nxt, tout_nxt;
  logic       busy_nxt;
  logic       e1, e2, pick, own_req;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_own, last_own_nxt;
`endif

  assign e1      = m1_breq && !(park_vld && !park_own);
  assign e2      = m2_breq && !(park_vld &&  park_own);
  assign own_req = owner ? m2_breq : m1_breq;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick = (e1 && e2) ? ~last_own : !e1;
`else
  assign pick = !e1;
`endif

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    resumed_nxt  = resumed;
    park_vld_nxt = park_vld;
    park_own_nxt = park_own;
    cnt_nxt      = cnt;
    m1_split_nxt = m1_split;
    m2_split_nxt = m2_split;
    tout_nxt     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_own_nxt = last_own;
`endif
    case (state)
      // RELEASE arbitrates like IDLE so a waiting master follows the 1-cycle gap directly
      IDLE, RELEASE: begin
        state_nxt   = IDLE;
        resumed_nxt = 1'b0;
        if (park_vld && !s3_split) begin
          state_nxt   = GRANT;
          owner_nxt   = park_own;
          resumed_nxt = 1'b1;
          cnt_nxt     = '0;
          if (park_own) m2_split_nxt = 1'b0;
          else          m1_split_nxt = 1'b0;
        end else if (e1 || e2) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          cnt_nxt   = '0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (state_nxt == GRANT) last_own_nxt = owner_nxt;
`endif
      end
      GRANT: begin
        // a resumed grant ignores the master's breq and further split requests
        if (tx_done) begin
          state_nxt = RELEASE;
          if (resumed) park_vld_nxt = 1'b0;
        end else if (!resumed && !own_req) begin
          state_nxt = RELEASE;
        end else if (!resumed && s3_split && !park_vld) begin
          state_nxt    = RELEASE;
          park_vld_nxt = 1'b1;
          park_own_nxt = owner;
          if (owner) m2_split_nxt = 1'b1;
          else       m1_split_nxt = 1'b1;
        end else if (cnt == 8'(GRANT_TIMEOUT - 1)) begin
          state_nxt = RELEASE;
          if (resumed) park_vld_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 8'd1;
          // pulse is registered, so it is raised one cycle early to land on the last grant cycle
          if (cnt == 8'(GRANT_TIMEOUT - 2)) tout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == GRANT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      resumed        <= 1'b0;
      park_vld       <= 1'b0;
      park_own       <= 1'b0;
      cnt            <= '0;
      m1_bgrant      <= 1'b0;
      m2_bgrant      <= 1'b0;
      m1_split       <= 1'b0;
      m2_split       <= 1'b0;
      s3_split_grant <= 1'b0;
      msel           <= 1'b0;
      bus_busy       <= 1'b0;
      timeout_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_own       <= 1'b1;
`endif
    end else begin
      state          <= state_nxt;
      owner          <= owner_nxt;
      resumed        <= resumed_nxt;
      park_vld       <= park_vld_nxt;
      park_own       <= park_own_nxt;
      cnt            <= cnt_nxt;
      m1_bgrant      <= busy_nxt && !owner_nxt;
      m2_bgrant      <= busy_nxt &&  owner_nxt;
      m1_split       <= m1_split_nxt;
      m2_split       <= m2_split_nxt;
      s3_split_grant <= busy_nxt && resumed_nxt;
      msel           <= busy_nxt && owner_nxt;
      bus_busy       <= busy_nxt;
      timeout_err    <= tout_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last_own       <= last_own_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter; output vector = {g1,g2,busy,msel,sgrant,split1,split2,tout}.
module tb_serial_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m1_breq = 1'b0, m2_breq = 1'b0, tx_done = 1'b0, s3_split = 1'b0;
  logic m1_bgrant, m2_bgrant, m1_split, m2_split, s3_split_grant, msel, bus_busy, timeout_err;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [7:0] G1   = 8'b1010_0000;
  localparam logic [7:0] G2   = 8'b0111_0000;
  localparam logic [7:0] NONE = 8'b0000_0000;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  serial_bus_arbiter #(.GRANT_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(m1_bgrant), .m2_bgrant(m2_bgrant),
    .m1_split(m1_split), .m2_split(m2_split),
    .tx_done(tx_done), .s3_split(s3_split),
    .s3_split_grant(s3_split_grant), .msel(msel),
    .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {m1_bgrant, m2_bgrant, bus_busy, msel, s3_split_grant, m1_split, m2_split, timeout_err};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m1_breq = 0; m2_breq = 0; tx_done = 0; s3_split = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state and basic grant timing
    #2;
    do_reset();
    chk("reset", outs(), NONE);
    m1_breq = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("m1_grant_c%0d", c), outs(), G1);
      if (c == 5) begin tx_done = 1; m1_breq = 0; end
    end
    tick(); tx_done = 0;
    chk("release_c6", outs(), NONE);
    tick();
    chk("idle_c7", outs(), NONE);

    // simultaneous requests, tx_done every grant
    do_reset();
    m1_breq = 1; m2_breq = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("arb_grant%0d", i), outs(), (RR && (i % 2 == 1)) ? G2 : G1);
      tx_done = 1;
      tick(); tx_done = 0;
      chk($sformatf("arb_release%0d", i), outs(), NONE);
    end
    m1_breq = 0; m2_breq = 0;
    tick();

    // split park and resume
    do_reset();
    m1_breq = 1; m2_breq = 1;
    tick(); chk("split_c1", outs(), G1);
    tick(); chk("split_c2", outs(), G1);
    tick(); chk("split_c3", outs(), G1);
    s3_split = 1;
    tick(); chk("park_c4", outs(), 8'b0000_0100);
    tick(); chk("m2_c5", outs(), 8'b0111_0100);
    tick(); chk("split_ignored_c6", outs(), 8'b0111_0100);
    s3_split = 0;
    tick(); chk("m2_c7", outs(), 8'b0111_0100);
    tx_done = 1; m2_breq = 0;
    tick(); tx_done = 0;
    chk("release_c8", outs(), 8'b0000_0100);
    tick(); chk("resume_c9", outs(), 8'b1010_1000);
    tx_done = 1;
    tick(); tx_done = 0;
    chk("resume_release_c10", outs(), NONE);
    tick(); chk("regrant_after_resume", outs(), G1);
    m1_breq = 0;
    tick(); chk("breq_drop_release", outs(), NONE);

    // grant timeout with GRANT_TIMEOUT = 8
    do_reset();
    m2_breq = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("tout_c%0d", c), outs(), (c == 8) ? 8'b0111_0001 : G2);
    end
    tick(); m2_breq = 0;
    chk("tout_release", outs(), NONE);
    tick();

    // asynchronous reset mid-grant
    do_reset();
    m1_breq = 1;
    tick(); tick();
    chk("pre_rst_grant", outs(), G1);
    #3 rst = 1;
    #1 chk("rst_mid_grant", outs(), NONE);
    tick(); rst = 0;

    // asynchronous reset mid-park, then 1-cycle grant latency after release
    tick(); chk("post_rst_grant", outs(), G1);
    s3_split = 1; m2_breq = 1;
    tick(); chk("park2", outs(), 8'b0000_0100);
    m2_breq = 0;
    #3 rst = 1;
    #1 chk("rst_mid_park", outs(), NONE);
    s3_split = 0;
    tick(); rst = 0;
    tick(); chk("grant_after_rst", outs(), G1);
    m1_breq = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
